// File: rtl/soc_pio_pkg.sv
// Shared register map and edge-type encodings for the SoC parallel I/O blocks.
package soc_pio_pkg;

  localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
  localparam logic [1:0] PIO_ADDR_DIR     = 2'd1;
  localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/soc_debounce_bit.sv
// One input bit: two-flop synchronizer, stability counter and accepted (stable) value.
module soc_debounce_bit #(
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter logic RESET_VAL       = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_bit,
  output logic stable
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt;

  // The counter only runs while the synchronized value disagrees with stable,
  // and clears on acceptance, so it can never pass TERMINAL.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_p0 <= RESET_VAL;
      sync_p1 <= RESET_VAL;
      stable  <= RESET_VAL;
      cnt     <= '0;
    end else begin
      meta_p0 <= in_bit;
      sync_p1 <= meta_p0;
      if (sync_p1 == stable) begin
        cnt <= '0;
      end else if (cnt == TERMINAL) begin
        stable <= sync_p1;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/soc_key_pio.sv
// Avalon-MM key/switch input port: debounced data, per-bit edge capture and masked level irq.
module soc_key_pio
  import soc_pio_pkg::*;
#(
  parameter int               WIDTH           = 4,
  parameter int               DEBOUNCE_CYCLES = 50000,
  parameter int               EDGE_TYPE       = 1,
  parameter logic [WIDTH-1:0] RESET_LEVEL     = '1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_p1;
  logic [WIDTH-1:0] edges;
  logic [WIDTH-1:0] edgecap;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] clr_mask;
  logic [31:0]      rd_mux;
  logic             wr;
  logic             unused_wdata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    soc_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_VAL      (RESET_LEVEL[i])
    ) u_deb (
      .clk    (clk),
      .reset_n(reset_n),
      .in_bit (in_port[i]),
      .stable (stable[i])
    );
  end

  assign wr           = chipselect && !write_n;
  assign unused_wdata = ^writedata;

  always_comb begin
    case (EDGE_TYPE)
      EDGE_RISE: edges = stable & ~stable_p1;
      EDGE_FALL: edges = ~stable & stable_p1;
      default:   edges = stable ^ stable_p1;
    endcase
  end

  always_comb begin
    clr_mask = '0;
    if (wr && address == PIO_ADDR_EDGECAP) clr_mask = writedata[WIDTH-1:0];
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      PIO_ADDR_DATA:    rd_mux[WIDTH-1:0] = stable;
      PIO_ADDR_IRQMASK: rd_mux[WIDTH-1:0] = irqmask;
      PIO_ADDR_EDGECAP: rd_mux[WIDTH-1:0] = edgecap;
      default:          rd_mux = '0;
    endcase
  end

  // Stage p1: delayed stable copy, edge capture (set beats clear), mask and read data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_p1 <= RESET_LEVEL;
      edgecap   <= '0;
      irqmask   <= '0;
      readdata  <= '0;
    end else begin
      stable_p1 <= stable;
      edgecap   <= (edgecap & ~clr_mask) | edges;
      readdata  <= rd_mux;
      if (wr && address == PIO_ADDR_IRQMASK) irqmask <= writedata[WIDTH-1:0];
    end
  end

  assign irq = |(edgecap & irqmask);

endmodule

// File: tb/tb_soc_key_pio.sv
// Bench for soc_key_pio (WIDTH=4, DEBOUNCE_CYCLES=4, falling edge) with cycle scoreboard.
module tb_soc_key_pio;

  localparam int W = 4;
  localparam int D = 4;

  logic         clk        = 1'b0;
  logic         reset_n    = 1'b0;
  logic [1:0]   address    = 2'd0;
  logic         chipselect = 1'b0;
  logic         write_n    = 1'b1;
  logic [31:0]  writedata  = 32'd0;
  logic [W-1:0] in_port    = 4'hF;
  logic [31:0]  readdata;
  logic         irq;

  int total = 0;
  int bad   = 0;

  // Reference model state: values as seen just after each clock edge.
  logic [W-1:0] m_s1, m_s2, m_st, m_std, m_cap, m_mask;
  logic [31:0]  m_rd = 32'd0;
  int           m_last[W];
  int           m_edge = 0;
  int           hold[W];

  typedef struct {
    logic [1:0]  addr;
    logic        cs;
    logic        wr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        irq;
  } vec_t;
  vec_t tbl[14];

  always #5 clk = ~clk;

  soc_key_pio #(
    .WIDTH          (W),
    .DEBOUNCE_CYCLES(D),
    .EDGE_TYPE      (1),
    .RESET_LEVEL    (4'hF)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .in_port   (in_port),
    .readdata  (readdata),
    .irq       (irq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // A bit is accepted once the synchronized sample has disagreed with the
  // accepted value for D consecutive edges since reset or the last agreement.
  task automatic model_step();
    logic [W-1:0] st_n;
    logic         wr;
    if (!reset_n) begin
      m_s1 = '1; m_s2 = '1; m_st = '1; m_std = '1;
      m_cap = '0; m_mask = '0; m_rd = '0;
      for (int b = 0; b < W; b++) m_last[b] = m_edge;
      return;
    end
    m_edge++;
    wr = chipselect && !write_n;
    case (address)
      2'd0:    m_rd = {28'd0, m_st};
      2'd2:    m_rd = {28'd0, m_mask};
      2'd3:    m_rd = {28'd0, m_cap};
      default: m_rd = 32'd0;
    endcase
    if (wr && address == 2'd3) m_cap = m_cap & ~writedata[W-1:0];
    m_cap = m_cap | (m_std & ~m_st);
    if (wr && address == 2'd2) m_mask = writedata[W-1:0];
    st_n = m_st;
    for (int b = 0; b < W; b++) begin
      if (m_s2[b] == m_st[b]) begin
        m_last[b] = m_edge;
      end else if (m_edge - m_last[b] >= D) begin
        st_n[b]   = m_s2[b];
        m_last[b] = m_edge;
      end
    end
    m_std = m_st;
    m_st  = st_n;
    m_s2  = m_s1;
    m_s1  = in_port;
  endtask

  initial forever begin
    @(posedge clk or negedge reset_n);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    check("sb_readdata", readdata, m_rd);
    check("sb_irq", {31'd0, irq}, {31'd0, |(m_cap & m_mask)});
  end

  initial begin
    tbl[0]  = '{2'd0, 1'b1, 1'b0, 32'h0,        32'hE, 1'b0};
    tbl[1]  = '{2'd1, 1'b1, 1'b1, 32'hFFFFFFFF, 32'h0, 1'b0};
    tbl[2]  = '{2'd2, 1'b0, 1'b1, 32'hF,        32'h0, 1'b0};
    tbl[3]  = '{2'd2, 1'b1, 1'b0, 32'h0,        32'h0, 1'b0};
    tbl[4]  = '{2'd2, 1'b1, 1'b1, 32'h1,        32'h0, 1'b1};
    tbl[5]  = '{2'd2, 1'b0, 1'b0, 32'h0,        32'h1, 1'b1};
    tbl[6]  = '{2'd3, 1'b1, 1'b1, 32'h2,        32'h3, 1'b1};
    tbl[7]  = '{2'd3, 1'b0, 1'b0, 32'h0,        32'h1, 1'b1};
    tbl[8]  = '{2'd0, 1'b1, 1'b1, 32'h0,        32'hE, 1'b1};
    tbl[9]  = '{2'd0, 1'b0, 1'b0, 32'h0,        32'hE, 1'b1};
    tbl[10] = '{2'd3, 1'b1, 1'b1, 32'h1,        32'h1, 1'b0};
    tbl[11] = '{2'd3, 1'b0, 1'b0, 32'h0,        32'h0, 1'b0};
    tbl[12] = '{2'd2, 1'b1, 1'b1, 32'hFFFFFFF0, 32'h1, 1'b0};
    tbl[13] = '{2'd2, 1'b0, 1'b0, 32'h0,        32'h0, 1'b0};

    // Reset with keys idle
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    tick();
    check("reset_data", readdata, 32'h0000000F);
    check("reset_irq", {31'd0, irq}, 32'd0);
    address = 2'd3;
    tick();
    check("reset_edgecap", readdata, 32'd0);

    // Debounced press on bit0
    address = 2'd0;
    in_port[0] = 1'b0;
    for (int j = 1; j <= 7; j++) begin
      tick();
      if (j == 6) check("press_data_before", readdata, 32'hF);
      if (j == 7) check("press_data_after", readdata, 32'hE);
    end
    address = 2'd3;
    tick();
    check("press_edgecap", readdata, 32'h1);
    check("press_irq_masked", {31'd0, irq}, 32'd0);

    // Glitch of D-1 cycles rejected, D cycles accepted
    address = 2'd0;
    in_port[1] = 1'b0;
    repeat (3) tick();
    in_port[1] = 1'b1;
    repeat (10) tick();
    check("glitch_data", readdata, 32'hE);
    address = 2'd3;
    tick();
    check("glitch_edgecap", readdata, 32'h1);
    in_port[1] = 1'b0;
    repeat (4) tick();
    in_port[1] = 1'b1;
    repeat (14) tick();
    tick();
    check("pulse_edgecap", readdata, 32'h3);

    // Register access table: mask, write-1-to-clear, ignored writes
    for (int i = 0; i < 14; i++) begin
      address    = tbl[i].addr;
      chipselect = tbl[i].cs;
      write_n    = !tbl[i].wr;
      writedata  = tbl[i].wd;
      tick();
      chipselect = 1'b0;
      write_n    = 1'b1;
      check($sformatf("tbl%0d_readdata", i), readdata, tbl[i].rd);
      check($sformatf("tbl%0d_irq", i), {31'd0, irq}, {31'd0, tbl[i].irq});
    end

    // Clear of bit2 lands on the edge that captures a new bit2 fall
    address = 2'd0;
    in_port[2] = 1'b0;
    repeat (6) tick();
    address = 2'd3; chipselect = 1'b1; write_n = 1'b0; writedata = 32'h4;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
    tick();
    check("simul_set_wins", readdata, 32'h4);
    chipselect = 1'b1; write_n = 1'b0; writedata = 32'h4;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
    tick();
    check("plain_clear", readdata, 32'h0);

    // Reset two cycles into a bit3 transition
    address = 2'd0;
    in_port[3] = 1'b0;
    repeat (3) tick();
    reset_n = 1'b0;
    #1;
    check("async_reset_readdata", readdata, 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    for (int j = 1; j <= 7; j++) begin
      tick();
      if (j == 1) check("rst_mid_restored", readdata, 32'hF);
      if (j == 6) check("rst_mid_before", readdata, 32'hF);
      if (j == 7) check("rst_mid_after", readdata, 32'h2);
    end
    address = 2'd3;
    tick();
    check("rst_mid_edgecap", readdata, 32'hD);

    // Randomized inputs and bus traffic against the model
    for (int b = 0; b < W; b++) hold[b] = $urandom_range(1, 8);
    for (int c = 0; c < 800; c++) begin
      for (int b = 0; b < W; b++) begin
        hold[b]--;
        if (hold[b] <= 0) begin
          in_port[b] = ~in_port[b];
          hold[b] = $urandom_range(1, 8);
        end
      end
      address    = 2'($urandom_range(0, 3));
      chipselect = 1'($urandom_range(0, 1));
      write_n    = ($urandom_range(0, 3) != 0);
      writedata  = $urandom;
      if (c == 400) reset_n = 1'b0;
      if (c == 403) reset_n = 1'b1;
      tick();
    end
    chipselect = 1'b0;
    write_n    = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
